// File: rtl/pc_fetch_sequencer.sv
// F-stage PC register: sequential fetch, live redirects, redirects captured while stalled.
// One-cycle PC update; stall_f freezes the PC and fetch count, and a redirect seen during the stall is held until release.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] IM_BASE   = 32'h0000_3000,
  parameter int          IM_WORDS  = 4096,
  parameter int          IM_ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_f,
  input  logic                 redir_valid,
  input  logic [31:0]          redir_target,
  output logic [31:0]          pc_f,
  output logic [31:0]          pc4_f,
  output logic [IM_ADDR_W-1:0] im_addr,
  output logic                 fetch_valid,
  output logic                 adel_f,
  output logic                 redir_pending,
  output logic [31:0]          fetch_count
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HELD = 1'b1
  } state_t;

  // 33-bit so the end-of-memory bound cannot wrap.
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        fv_q;
  logic [31:0] cnt_q;
  logic        borrow;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    if (!stall_f) begin
      state_d = RUN;
      if (redir_valid) begin
        pc_d = redir_target;
      end else if (state_q == HELD) begin
        pc_d = tgt_q;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end else if (redir_valid) begin
      // Latest redirect during a stall wins.
      state_d = HELD;
      tgt_d   = redir_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      tgt_q   <= 32'd0;
      fv_q    <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      fv_q    <= 1'b1;
      if (fv_q && !stall_f) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  // Word index of (pc - IM_BASE); borrow out of the byte-offset bits keeps it exact for any base.
  assign borrow  = pc_q[1:0] < IM_BASE[1:0];
  assign im_addr = pc_q[IM_ADDR_W+1:2] - IM_BASE[IM_ADDR_W+1:2] - IM_ADDR_W'(borrow);

  assign pc_f          = pc_q;
  assign pc4_f         = pc_q + 32'd4;
  assign fetch_valid   = fv_q;
  assign redir_pending = (state_q == HELD);
  assign fetch_count   = cnt_q;
  assign adel_f        = fv_q && ((pc_q[1:0] != 2'b00) ||
                                  (pc_q < IM_BASE) ||
                                  ({1'b0, pc_q} >= IM_LIMIT));

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed vectors, a behavioural model checked every cycle, plus literal spot checks.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_f = 1'b0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_target = 32'd0;
  logic [31:0] pc_f;
  logic [31:0] pc4_f;
  logic [11:0] im_addr;
  logic        fetch_valid;
  logic        adel_f;
  logic        redir_pending;
  logic [31:0] fetch_count;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  pc_fetch_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .stall_f      (stall_f),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .pc_f         (pc_f),
    .pc4_f        (pc4_f),
    .im_addr      (im_addr),
    .fetch_valid  (fetch_valid),
    .adel_f       (adel_f),
    .redir_pending(redir_pending),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  // Behavioural model of the architectural state.
  logic [31:0] m_pc = 32'h3000;
  logic [31:0] m_tgt = 32'd0;
  bit          m_pend = 1'b0;
  bit          m_fv = 1'b0;
  logic [31:0] m_cnt = 32'd0;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 32'h3000; m_tgt = 32'd0; m_pend = 1'b0; m_fv = 1'b0; m_cnt = 32'd0;
    end else begin
      if (!stall_f) begin
        if (m_fv) m_cnt = m_cnt + 1;
        if (redir_valid)  m_pc = redir_target;
        else if (m_pend)  m_pc = m_tgt;
        else              m_pc = m_pc + 4;
        m_pend = 1'b0;
      end else if (redir_valid) begin
        m_tgt  = redir_target;
        m_pend = 1'b1;
      end
      m_fv = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%08h expected=%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_im_addr(input logic [31:0] pc);
    logic [31:0] off;
    off = pc - 32'h3000;
    return (off / 4) % 4096;
  endfunction

  function automatic logic exp_adel(input logic [31:0] pc, input bit fv);
    return fv && ((pc % 4) != 0 || pc < 32'h3000 || pc >= 32'h7000);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pc_f",          pc_f,                 m_pc);
      check("model_pc4_f",         pc4_f,                m_pc + 32'd4);
      check("model_im_addr",       32'(im_addr),         exp_im_addr(m_pc));
      check("model_fetch_valid",   32'(fetch_valid),     32'(m_fv));
      check("model_adel_f",        32'(adel_f),          32'(exp_adel(m_pc, m_fv)));
      check("model_redir_pending", 32'(redir_pending),   32'(m_pend));
      check("model_fetch_count",   fetch_count,          m_cnt);
    end
  end

  task automatic cyc(input bit r, input bit s, input bit v, input logic [31:0] t);
    reset = r; stall_f = s; redir_valid = v; redir_target = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    cyc(1, 0, 0, 32'd0);
    chk_en = 1'b1;
    cyc(1, 0, 0, 32'd0);
    check("rst_pc",      pc_f,                 32'h3000);
    check("rst_fv",      32'(fetch_valid),     32'd0);
    check("rst_pend",    32'(redir_pending),   32'd0);
    check("rst_cnt",     fetch_count,          32'd0);
    check("rst_adel",    32'(adel_f),          32'd0);

    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 32'd0);
    check("seq_pc",      pc_f,                 32'h3010);
    check("seq_im_addr", 32'(im_addr),         32'd4);
    check("seq_cnt",     fetch_count,          32'd3);
    check("seq_fv",      32'(fetch_valid),     32'd1);

    cyc(0, 0, 1, 32'h3040);
    check("redir_pc",    pc_f,                 32'h3040);
    cyc(0, 0, 0, 32'd0);
    check("redir_pc_next", pc_f,               32'h3044);

    cyc(0, 0, 1, 32'h3020);
    cyc(0, 1, 1, 32'h3100);
    check("stall1_pend", 32'(redir_pending),   32'd1);
    cyc(0, 1, 1, 32'h3200);
    cyc(0, 1, 0, 32'd0);
    check("stall_hold_pc",  pc_f,              32'h3020);
    check("stall_hold_cnt", fetch_count,       32'd6);
    cyc(0, 0, 0, 32'd0);
    check("release_pc",   pc_f,                32'h3200);
    check("release_pend", 32'(redir_pending),  32'd0);
    check("release_cnt",  fetch_count,         32'd7);

    cyc(0, 1, 1, 32'h3100);
    cyc(0, 0, 1, 32'h3300);
    check("live_wins_pc",   pc_f,              32'h3300);
    check("live_wins_pend", 32'(redir_pending), 32'd0);
    cyc(0, 0, 0, 32'd0);
    check("live_wins_next", pc_f,              32'h3304);

    cyc(0, 0, 1, 32'h3002);
    check("misalign_adel", 32'(adel_f),        32'd1);
    cyc(0, 0, 0, 32'd0);
    check("misalign_next", pc_f,               32'h3006);
    cyc(0, 0, 1, 32'h2FFC);
    check("below_adel",    32'(adel_f),        32'd1);
    check("below_im_addr", 32'(im_addr),       32'hFFF);
    cyc(0, 0, 1, 32'h7000);
    check("above_adel",    32'(adel_f),        32'd1);
    cyc(0, 0, 1, 32'h6FFC);
    check("edge_adel",     32'(adel_f),        32'd0);
    check("edge_im_addr",  32'(im_addr),       32'd4095);
    cyc(0, 0, 1, 32'hFFFF_FFFC);
    check("wrap_pc4",      pc4_f,              32'd0);
    cyc(0, 0, 0, 32'd0);
    check("wrap_pc",       pc_f,               32'd0);

    cyc(0, 1, 1, 32'h3100);
    cyc(1, 1, 1, 32'h3500);
    check("rst_stall_pc",   pc_f,              32'h3000);
    check("rst_stall_pend", 32'(redir_pending), 32'd0);
    check("rst_stall_cnt",  fetch_count,       32'd0);
    check("rst_stall_fv",   32'(fetch_valid),  32'd0);
    cyc(0, 0, 0, 32'd0);
    check("post_rst_pc",    pc_f,              32'h3004);
    cyc(0, 0, 0, 32'd0);
    check("post_rst_pc2",   pc_f,              32'h3008);
    check("post_rst_cnt",   fetch_count,       32'd1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Fetch-stage PC register and sequencer. It consumes the redirect pair (select + target) produced by the D-stage next-PC logic for beq/bne/jal/jr, and drives the F-stage PC and instruction-memory word address. Redirects that arrive while F is stalled are captured, so no branch or jump is lost. It also flags illegal fetch addresses and counts issued fetches for debug.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset.
IM_BASE, 32'h0000_3000, byte address of instruction-memory word 0.
IM_WORDS, 4096, instruction-memory depth in words.
IM_ADDR_W, 12, width of im_addr; must equal clog2(IM_WORDS).

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall_f  input  1  hazard-unit freeze of F stage; PC holds while high
redir_valid  input  1  redirect select from next-PC logic (taken branch or jump)
redir_target  input  32  redirect target byte address
pc_f  output  32  current fetch PC (registered)
pc4_f  output  32  pc_f + 4, combinational
im_addr  output  IM_ADDR_W  word index into instruction memory, combinational
fetch_valid  output  1  registered; F-stage instruction is meaningful
adel_f  output  1  combinational fetch address error
redir_pending  output  1  registered; a redirect is captured and waiting for stall release
fetch_count  output  32  registered count of issued fetches

Behaviour:
- Reset (reset=1 at posedge):
  - pc_f=RESET_PC, fetch_valid=0, redir_pending=0, pending target register=0, fetch_count=0.
  - Reset overrides every other input. Reset mid-stall discards any pending redirect.
- fetch_valid goes to 1 on the first edge with reset=0 and stays 1 until the next reset.
- Internal states: RUN (redir_pending=0) and HELD (redir_pending=1).
- Next-PC selection, per posedge with reset=0 and stall_f=0, highest priority first:
  1. redir_valid=1 -> pc_f<=redir_target.
  2. redir_pending=1 -> pc_f<=pending target.
  3. otherwise -> pc_f<=pc_f+4.
  - After any of these, redir_pending<=0 and the state returns to RUN.
- Live-over-pending rule: when redir_valid=1 and redir_pending=1 with stall_f=0, the live target wins and the pending one is dropped.
- Posedge with reset=0 and stall_f=1:
  - pc_f holds.
  - If redir_valid=1: pending target<=redir_target and redir_pending<=1. A later redirect overwrites an earlier one (latest wins).
  - If redir_valid=0: pending state is unchanged.
- Delay slot: the instruction fetched in the same cycle a redirect is applied is the delay slot. The sequencer never squashes or inserts bubbles.
- Arithmetic: pc_f+4 is 32-bit modulo, so 32'hFFFF_FFFC+4 wraps to 0. im_addr=(pc_f-IM_BASE)[IM_ADDR_W+1:2], taken modulo 2^32 before slicing.
- adel_f=1 when any of the following holds; it is 0 whenever fetch_valid=0:
  - pc_f[1:0]!=0, or
  - pc_f<IM_BASE (unsigned), or
  - pc_f>=IM_BASE+4*IM_WORDS (unsigned).
- adel_f does not stop sequencing. The PC keeps advancing and downstream decides.
- fetch_count increments by 1 (modulo 2^32) on each posedge where reset=0, fetch_valid=1 and stall_f=0. It does not increment on the first post-reset edge, because fetch_valid was 0.
- The redirect target is used as-is. No alignment masking is applied.

Test Plan:
- Reset then 4 free cycles -> pc_f 0x3000, 0x3004, 0x3008, 0x300C, 0x3010; im_addr 0..4; fetch_valid=1 from cycle 1; fetch_count=3 after 4th edge; adel_f=0.
- At pc_f=0x3010, pulse redir_valid=1 with target 0x3040 (stall_f=0) -> next pc_f=0x3040, then 0x3044; redir_pending stays 0.
- stall_f=1 for 3 cycles at pc_f=0x3020, redir_valid pulsed with 0x3100 in stall cycle 1 and 0x3200 in cycle 2 -> pc_f holds 0x3020; redir_pending=1 from cycle 2; after release pc_f=0x3200, redir_pending=0; fetch_count frozen during stall.
- redir_pending=1 (target 0x3100) and stall_f drops with redir_valid=1 target 0x3300 -> pc_f=0x3300, pending cleared.
- Address error cases, each giving adel_f=1 (with the PC continuing to advance where noted):
  - redir_target=0x3002 -> pc_f=0x3002, next pc_f=0x3006.
  - target 0x0000_2FFC.
  - target 0x0000_7000 (=IM_BASE+16384).
  - Boundary check: target 0x6FFC gives adel_f=0, im_addr=4095.
- Assert reset while stall_f=1 and redir_pending=1 -> pc_f=0x3000, redir_pending=0, fetch_count=0, fetch_valid=0. After release, sequential fetch from 0x3000 with no stale redirect.
